lifo_ext: RTL
=============

LIFO_EXT -- requirements
Module: lifo_ext

Interface
REQ-001 Parameter DWIDTH, default 8, data word width in bits.
REQ-002 Parameter AWIDTH, default 4, address width; depth DEPTH = 2**AWIDTH.
REQ-003 Parameter AF_LEVEL, default 2**AWIDTH-2, almost-full threshold in words.
REQ-004 Parameter AE_LEVEL, default 2, almost-empty threshold in words.
REQ-005 clk_i  input  1  single clock; all logic SHALL be sampled on its rising edge.
REQ-006 srst_i  input  1  reset; synchronous, active-high.
REQ-007 wrreq_i  input  1  push request.
REQ-008 data_i  input  DWIDTH  push data.
REQ-009 rdreq_i  input  1  pop request.
REQ-010 q_o  output  DWIDTH  popped data, registered.
REQ-011 q_valid_o  output  1  one-cycle pulse marking new q_o.
REQ-012 empty_o, full_o, almost_empty_o, almost_full_o  output  1 each  registered status flags.
REQ-013 usedw_o  output  AWIDTH+1  current word count, 0..DEPTH.
REQ-014 overflow_o, underflow_o  output  1 each  sticky error flags (see Configuration).

Function
REQ-015 Accepted push wr_acc SHALL be wrreq_i && (!full_o || rdreq_i); accepted pop rd_acc SHALL be rdreq_i && !empty_o.
REQ-016 Rejected requests SHALL leave storage, count, pointer and q_o unchanged.
REQ-017 wr_acc only: data_i written at top+1, usedw +1.
REQ-018 rd_acc only: top word driven to q_o next cycle, q_valid_o=1 that cycle, usedw -1.
REQ-019 wr_acc and rd_acc together (replace-top): q_o gets the old top word, data_i overwrites the top slot, usedw unchanged; legal when full.
REQ-020 wrreq_i and rdreq_i together while empty: push accepted, pop rejected.
REQ-021 Pop latency SHALL be exactly 1 cycle; q_o SHALL hold its value between accepted pops.
REQ-022 empty_o = (usedw==0), full_o = (usedw==DEPTH), almost_empty_o = (usedw<=AE_LEVEL), almost_full_o = (usedw>=AF_LEVEL); all SHALL update in the same cycle as usedw_o.
REQ-023 Stack pointer SHALL be AWIDTH+1 bits internally; no wrap-around SHALL occur at DEPTH or 0.
REQ-024 Storage SHALL be a synchronous single-clock RAM with old-data read-during-write.

Reset
REQ-025 On srst_i: usedw_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, q_valid_o=0, q_o=0, overflow_o=0, underflow_o=0.
REQ-026 srst_i SHALL take priority over any simultaneous request; RAM contents need not clear.
REQ-027 A pop accepted in the cycle before reset SHALL NOT produce q_valid_o after reset.

Configuration
REQ-028 Macro LIFO_EXT_ERR_FLAGS_EN: defined -> overflow_o sets on wrreq_i && full_o && !rdreq_i, underflow_o sets on rdreq_i && empty_o; both sticky until srst_i.
REQ-029 Macro undefined -> overflow_o and underflow_o tied to 0 and no error logic synthesised; REQ-016 still holds.

Structure
REQ-030 Package lifo_ext_pkg SHALL hold a request-type enum (IDLE, PUSH, POP, REPLACE) and a depth helper function.
REQ-031 Storage SHALL be sub-module lifo_ext_ram (DWIDTH x DEPTH, one write port, one registered read port).

Verification (AWIDTH=2, DWIDTH=8, AF_LEVEL=3, AE_LEVEL=1)
REQ-032 Push 0x11,0x22,0x33,0x44 -> full_o=1, almost_full_o=1 after 3rd push, usedw_o=4.
REQ-033 Then four pops -> q_o sequence 0x44,0x33,0x22,0x11, one q_valid_o pulse each, empty_o=1 after the last pop.
REQ-034 Stack holding 0x11,0x22; push 0x99 with pop same cycle -> q_o=0x22, usedw_o=2; next pop -> q_o=0x99.
REQ-035 Full stack, push 0x55 alone -> rejected, usedw_o=4, overflow_o=1 (macro on) / 0 (macro off); empty stack, pop alone -> no q_valid_o, underflow_o=1 (macro on).
REQ-036 Push 0xAA, push 0xBB, pop with srst_i asserted same cycle -> next cycle usedw_o=0, empty_o=1, q_valid_o=0, q_o=0.

Source files
------------

// File: rtl/lifo_ext_pkg.sv
// Shared types and helpers for the lifo_ext stack.
// Request classification and depth calculation used by the top and the RAM.
package lifo_ext_pkg;

  // Encoded as {rd_acc, wr_acc} so decode is a plain cast.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PUSH    = 2'b01,
    POP     = 2'b10,
    REPLACE = 2'b11
  } req_e;

  function automatic int lifo_depth(input int awidth);
    return 1 << awidth;
  endfunction

  function automatic req_e decode_req(input logic wr_acc, input logic rd_acc);
    return req_e'({rd_acc, wr_acc});
  endfunction

endpackage

// File: rtl/lifo_ext_ram.sv
// Single-clock DWIDTH x DEPTH storage: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module lifo_ext_ram
  import lifo_ext_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  localparam int DEPTH = lifo_depth(AWIDTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register is resettable so the popped-data port starts at zero.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lifo_ext.sv
// LIFO stack with registered pop data, status flags and word count.
// Optional sticky overflow/underflow flags are built when LIFO_EXT_ERR_FLAGS_EN is defined.
module lifo_ext
  import lifo_ext_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 4,
  parameter int AF_LEVEL = 2**AWIDTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              q_valid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int              DEPTH   = lifo_depth(AWIDTH);
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(AE_LEVEL);
  localparam logic [AWIDTH:0] ONE_C   = (AWIDTH+1)'(1);

  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic              empty_q, full_q, ae_q, af_q, q_valid_q;
  logic              wr_acc, rd_acc;
  req_e              req;
  logic              ram_we, ram_re;
  logic [AWIDTH-1:0] ram_waddr, top_addr;

  assign wr_acc = wrreq_i && (!full_q || rdreq_i);
  assign rd_acc = rdreq_i && !empty_q;
  assign req    = decode_req(wr_acc, rd_acc);

  // Count doubles as the stack pointer: top word lives at usedw-1.
  assign top_addr = usedw_q[AWIDTH-1:0] - AWIDTH'(1);

  always_comb begin
    usedw_d   = usedw_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = usedw_q[AWIDTH-1:0];
    unique case (req)
      PUSH: begin
        ram_we  = 1'b1;
        usedw_d = usedw_q + ONE_C;
      end
      POP: begin
        ram_re  = 1'b1;
        usedw_d = usedw_q - ONE_C;
      end
      REPLACE: begin
        ram_we    = 1'b1;
        ram_re    = 1'b1;
        ram_waddr = top_addr;
      end
      default: ;
    endcase
    if (srst_i) begin
      ram_we = 1'b0;
      ram_re = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      usedw_q   <= '0;
      empty_q   <= 1'b1;
      ae_q      <= 1'b1;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      q_valid_q <= 1'b0;
    end else begin
      usedw_q   <= usedw_d;
      empty_q   <= (usedw_d == '0);
      full_q    <= (usedw_d == DEPTH_C);
      ae_q      <= (usedw_d <= AE_C);
      af_q      <= (usedw_d >= AF_C);
      q_valid_q <= rd_acc;
    end
  end

  lifo_ext_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (data_i),
    .re_i    (ram_re),
    .raddr_i (top_addr),
    .rdata_o (q_o)
  );

`ifdef LIFO_EXT_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wrreq_i && full_q && !rdreq_i) overflow_q <= 1'b1;
      if (rdreq_i && empty_q)            underflow_q <= 1'b1;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

  assign q_valid_o      = q_valid_q;
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_empty_o = ae_q;
  assign almost_full_o  = af_q;
  assign usedw_o        = usedw_q;

endmodule
